// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2,
        DONE      = 2'd3
    } fill_state_t;

    // Word offset within a line (bits above the byte offset).
    function automatic int off_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag is whatever remains above byte offset, word offset and index.
    function automatic int tag_width(input int num_lines, input int words_per_line);
        return ADDR_W - 1 - $clog2(words_per_line) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Word storage for the instruction cache: one synchronous write port, one asynchronous read port.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 8,
    localparam int IDX_W         = idx_width(NUM_LINES),
    localparam int OFF_W         = off_width(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_line,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_line,
    input  logic [OFF_W-1:0]  rd_word,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [NUM_LINES][WORDS_PER_LINE];

    // NOTE: storage has no reset; the line valid bits decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_line][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem[rd_line][rd_word];

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with combinational hit path and a word-by-word line-fill FSM.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_fill
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [WORD_W-1:0] if_instr,
    output logic              if_valid,
    output logic              if_stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_data_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int OFF_W   = off_width(WORDS_PER_LINE);
    localparam int IDX_W   = idx_width(NUM_LINES);
    localparam int TAG_W   = tag_width(NUM_LINES, WORDS_PER_LINE);
    localparam int LINE_W  = ADDR_W - OFF_W - 1;
    localparam int IDX_LSB = OFF_W + 1;
    localparam int TAG_LSB = OFF_W + IDX_W + 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    fill_state_t       state, state_nxt;
    logic [OFF_W-1:0]  counter;
    logic [LINE_W-1:0] fill_line;
    logic              flush_pend;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]  tag_arr [NUM_LINES];

    logic [OFF_W-1:0]  req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit, miss, fill_we;
    logic              unused_byte_offset;

    assign req_word = if_addr[OFF_W:1];
    assign req_idx  = if_addr[TAG_LSB-1:IDX_LSB];
    assign req_tag  = if_addr[ADDR_W-1:TAG_LSB];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LINE_W-1:IDX_W];
    assign unused_byte_offset = if_addr[0];

    // Lookup is only honoured in IDLE so a fill in progress never races a hit.
    assign hit  = if_req && (state == IDLE) && valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign miss = if_req && (state == IDLE) && !hit;

    assign if_valid  = hit;
    assign if_stall  = if_req && !hit;
    assign if_instr  = hit ? rd_data : '0;
    assign mem_rd_en = (state == FILL_REQ);
    assign mem_addr  = mem_rd_en ? {fill_line, counter, 1'b0} : '0;
    assign fill_we   = (state == FILL_WAIT) && mem_data_valid;

    icache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data (
        .clk     (clk),
        .we      (fill_we),
        .wr_line (fill_idx),
        .wr_word (counter),
        .wr_data (mem_data),
        .rd_line (req_idx),
        .rd_word (req_word),
        .rd_data (rd_data)
    );

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (miss) state_nxt = FILL_REQ;
            FILL_REQ:  state_nxt = FILL_WAIT;
            FILL_WAIT: if (mem_data_valid) state_nxt = (counter == LAST_WORD) ? DONE : FILL_REQ;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // NOTE: reset is asynchronous and active-high; state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            fill_line  <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
        end else begin
            state <= state_nxt;

            unique case (state)
                IDLE: begin
                    if (miss) begin
                        fill_line <= if_addr[ADDR_W-1:IDX_LSB];
                        counter   <= '0;
                    end
                end
                FILL_WAIT: begin
                    if (mem_data_valid && (counter != LAST_WORD)) begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE:    counter <= '0;
                default: ;
            endcase

            // A flush seen during a fill is deferred and also kills the line just filled.
            if (state == DONE) begin
                if (flush_pend || if_flush) begin
                    valid <= '0;
                end else begin
                    valid[fill_idx] <= 1'b1;
                end
                flush_pend <= 1'b0;
            end else if (if_flush) begin
                if (state == IDLE) begin
                    valid <= '0;
                end else begin
                    flush_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DONE) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: fills, hits, conflicts, flushes and reset mid-fill.
// Memory responder answers each read two cycles later with a data pattern derived from the address.
module tb_icache_fill;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic [15:0] if_instr;
    logic        if_valid;
    logic        if_stall;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_data_valid;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_log [$];
    logic [15:0] pend_addr;
    int          pend = -1;

    icache_fill dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .if_stall       (if_stall),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lines with address bit 7 set return 0xB000+word, others 0xA000+word.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a[7] ? 16'hB000 : 16'hA000) + {13'd0, a[3:1]};
    endfunction

    initial begin
        mem_data       = 16'h0000;
        mem_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            mem_data_valid = 1'b0;
            if (pend > 0) pend--;
            if (pend == 0) begin
                mem_data_valid = 1'b1;
                mem_data       = mem_word(pend_addr);
                pend           = -1;
            end
            if (mem_rd_en === 1'b1) begin
                rd_log.push_back(mem_addr);
                pend_addr = mem_addr;
                pend      = 2;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_hit(input string tag);
        int n = 0;
        while (if_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_hit_arrives"}, {31'd0, if_valid}, 32'd1);
    endtask

    task automatic wait_reads(input int count);
        int n = 0;
        while (rd_log.size() < count && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    // Full miss-to-hit sequence on one line, checking the eight read addresses and the first word.
    task automatic run_fill(input string tag, input logic [15:0] addr, input logic [15:0] exp_instr);
        @(negedge clk);
        rd_log.delete();
        if_addr = addr;
        if_req  = 1'b1;
        #1;
        check({tag, "_stall"}, {31'd0, if_stall}, 32'd1);
        check({tag, "_valid_low"}, {31'd0, if_valid}, 32'd0);
        wait_hit(tag);
        check({tag, "_reads"}, rd_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] got;
            got = (rd_log.size() > i) ? rd_log[i] : 16'hxxxx;
            check($sformatf("%s_rd_addr%0d", tag, i), {16'd0, got}, {16'd0, addr + 16'(2 * i)});
        end
        check({tag, "_instr"}, {16'd0, if_instr}, {16'd0, exp_instr});
    endtask

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 16'h0000;
        if_flush = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_stall", {31'd0, if_stall}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_instr", {16'd0, if_instr}, 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", {16'd0, hit_count}, 32'd0);
        check("rst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // No request: nothing starts.
        if_addr = 16'h0010;
        repeat (4) @(negedge clk);
        #1;
        check("idle_noreq_stall", {31'd0, if_stall}, 32'd0);
        check("idle_noreq_reads", rd_log.size(), 32'd0);

        // Cold miss, then sequential hits across the line.
        run_fill("cold", 16'h0010, 16'hA000);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if_addr = 16'h0010 + 16'(2 * i);
            #1;
            check($sformatf("seq_valid%0d", i), {31'd0, if_valid}, 32'd1);
            check($sformatf("seq_stall%0d", i), {31'd0, if_stall}, 32'd0);
            check($sformatf("seq_instr%0d", i), {16'd0, if_instr}, {16'd0, 16'hA000 + 16'(i)});
        end

        // Conflict: same index, different tag evicts, and the old line misses again.
        run_fill("conf_b", 16'h0090, 16'hB000);
        run_fill("conf_a", 16'h0010, 16'hA000);

        // Flush during the third FILL_WAIT of a fill to 0x0020.
        @(negedge clk);
        rd_log.delete();
        if_addr = 16'h0020;
        wait_reads(3);
        @(negedge clk);
        if_flush = 1'b1;
        #1;
        check("flush_fill_stall", {31'd0, if_stall}, 32'd1);
        @(negedge clk);
        if_flush = 1'b0;
        begin
            int n = 0;
            bit saw_valid = 1'b0;
            logic [15:0] a9;
            while (rd_log.size() < 9 && n < 200) begin
                @(negedge clk);
                #1;
                if (if_valid === 1'b1) saw_valid = 1'b1;
                n++;
            end
            check("flush_no_hit", {31'd0, saw_valid}, 32'd0);
            check("flush_reads", rd_log.size(), 32'd9);
            a9 = (rd_log.size() > 8) ? rd_log[8] : 16'hxxxx;
            check("flush_last_rd", {16'd0, (rd_log.size() > 7) ? rd_log[7] : 16'hxxxx}, 32'h002E);
            check("flush_refill_rd", {16'd0, a9}, 32'h0020);
        end
        wait_hit("flush_refill");
        check("flush_refill_instr", {16'd0, if_instr}, 32'hA000);
        @(negedge clk);
        if_addr = 16'h0010;
        #1;
        check("flush_old_line_miss", {31'd0, if_stall}, 32'd1);
        wait_hit("flush_old_line");
        @(negedge clk);
        if_req = 1'b0;

        // Asynchronous reset during FILL_WAIT; the late response must be ignored.
        @(negedge clk);
        rd_log.delete();
        if_addr = 16'h0030;
        if_req  = 1'b1;
        wait_reads(1);
        @(negedge clk);
        rst    = 1'b1;
        if_req = 1'b0;
        #1;
        check("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("arst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("arst_stall", {31'd0, if_stall}, 32'd0);
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("arst_late_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("arst_late_reads", rd_log.size(), 32'd1);
        run_fill("arst_next", 16'h0010, 16'hA000);

`ifdef ICACHE_STATS_EN
        // One miss plus seven hit cycles since reset.
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            if_addr = 16'h0010 + 16'(2 * i);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("stats_hits", {16'd0, hit_count}, 32'd7);
        check("stats_misses", {16'd0, miss_count}, 32'd1);
        @(negedge clk);
        force dut.hit_count = 16'hFFFF;
        #1;
        release dut.hit_count;
        @(negedge clk);
        if_addr = 16'h0010;
        if_req  = 1'b1;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("stats_saturate", {16'd0, hit_count}, 32'h0000FFFF);
`endif

        // Flush in IDLE: same-cycle lookup still sees the old line, the next cycle misses.
        @(negedge clk);
        if_addr  = 16'h0010;
        if_req   = 1'b1;
        if_flush = 1'b1;
        #1;
        check("idle_flush_same_hit", {31'd0, if_valid}, 32'd1);
        @(negedge clk);
        if_flush = 1'b0;
        #1;
        check("idle_flush_next_miss", {31'd0, if_stall}, 32'd1);
        wait_hit("idle_flush_refill");
        @(negedge clk);
        if_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
